mem_fetch_ctrl: RTL and testbench
=================================

# mem_fetch_ctrl

Parametrised host-fetch controller: it arbitrates NUM_CH on-chip requesters (weights, matrix, instructions, ...) onto the single Raspberry Pi byte link. Requesters are served in round-robin order. For each grant it runs a request/acknowledge handshake with the host, then receives a multi-beat burst and returns each beat tagged with the owning channel. It sits between the TPU's load units and the host pin interface, replacing the fixed three-source single-byte controller.

## Interface
Parameters:
- NUM_CH, 3, number of requesters; channel k is encoded on the link as k+1
- DATA_W, 8, width of a link data beat
- LEN_W, 4, burst-length field width; a burst is ch_len+1 beats (1..2^LEN_W)
- TIMEOUT_CYC, 255, cycles allowed with no host progress (used only with MEM_FETCH_TIMEOUT_EN)
- TYPE_W = $clog2(NUM_CH+1), localparam

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- ch_req  in  NUM_CH  level request per channel; held until that channel's ch_done
- ch_len  in  NUM_CH*LEN_W  per-channel burst length minus one; channel k uses bits [k*LEN_W +: LEN_W]
- req_type  out  TYPE_W  granted channel+1; 0 when no request is pending
- req_valid  out  1  request strobe to host
- req_len  out  LEN_W  captured ch_len of the granted channel
- rpi_ready  in  1  host accepts the request when it is high together with req_valid
- rpi_valid  in  1  host data beat valid
- rpi_in_data  in  DATA_W  host data
- output_sel  out  TYPE_W  channel+1 for out_data
- out_data  out  DATA_W  registered beat
- data_ready  out  1  one-cycle strobe per delivered beat
- ch_done  out  NUM_CH  one-hot, one-cycle pulse when a channel's burst ends
- busy  out  1  high in every state other than IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- All outputs reset to 0. The round-robin pointer resets to channel 0 and the state to IDLE.
- States and transitions:
  - IDLE: if any ch_req is high, grant the first requesting channel at or after the pointer. Capture its ch_len into req_len and the beat counter. Go to REQ.
  - REQ: hold req_valid=1, req_type and req_len stable. When rpi_ready=1, go to XFER with req_valid=0.
  - XFER: each cycle with rpi_valid=1 registers rpi_in_data into out_data, sets output_sel to the granted channel+1, and decrements the counter. The beat that takes the counter past 0 moves the block to DONE.
  - DONE: one cycle. Raise the granted bit of ch_done and clear req_type. Advance the pointer to (grant+1) mod NUM_CH. Go to IDLE.
- Arbitration happens only in IDLE. ch_req and ch_len changes during a burst have no effect.
- rpi_valid is ignored in IDLE, REQ and DONE. rpi_ready is ignored outside REQ.
- If rpi_ready and rpi_valid are both high in REQ, only the request is accepted; the data beat is dropped.
- Each requester must drop ch_req within one cycle of seeing ch_done. If it is still high in IDLE, the channel is re-granted under normal round-robin.
- A rst assertion mid-burst aborts the burst immediately. No ch_done is issued and no partial data is flushed.

## Timing
- Grant latency: ch_req high in IDLE at edge E gives req_valid=1 after E.
- Request acceptance: rpi_ready sampled high at edge E gives XFER after E.
- Data latency is 1 cycle: rpi_valid beat at edge E gives data_ready, out_data and output_sel valid after E, for exactly one cycle.
- The last beat's data_ready coincides with ch_done, which is driven during DONE.
- Minimum burst of 1 beat takes 4 cycles from grant to IDLE: REQ, XFER, DONE, IDLE.
- Back-to-back beats on consecutive cycles are sustained at 1 beat/cycle.

## Configuration
- MEM_FETCH_TIMEOUT_EN defined:
  - A watchdog counts cycles in REQ and XFER and clears on every handshake and every accepted beat.
  - Reaching TIMEOUT_CYC forces DONE: ch_done pulses for the granted channel, timeout_err pulses in the same cycle, the pointer advances, and no data_ready is produced for the missing beats.
- Not defined: no watchdog; the block waits indefinitely in REQ or XFER, and timeout_err is tied to 0.

## Structure
- Package mem_fetch_pkg holds:
  - the state enum (IDLE, REQ, XFER, DONE)
  - the idle req_type code (0)
  - a function mapping channel index to link code (idx+1)
- Sub-module rr_arbiter (NUM_CH parameter): request vector, pointer and enable in; one-hot grant and grant index out. It is purely combinational apart from the pointer register.

## Test plan
- Reset, single request: NUM_CH=3, ch_req=3'b001, ch_len[0]=0, host replies rpi_ready then one beat 0xA5. Expect req_type=1 and req_len=0, then one data_ready with out_data=0xA5 and output_sel=1, then ch_done=3'b001.
- Burst: channel 2 with ch_len=3 and four consecutive beats 0x10..0x13. Expect four consecutive data_ready cycles, output_sel=3, ch_done=3'b100 on the fourth.
- Round-robin: all three ch_req held high, each requester re-asserting after its ch_done. Expect grant order 0,1,2,0.
- Simultaneous rpi_ready and rpi_valid in REQ with data 0xFF. Expect the request accepted, no data_ready that cycle, and the beat count unchanged.
- Reset mid-burst after 2 of 4 beats. Expect all outputs 0 on the next cycle, no ch_done, and the next grant going to channel 0.
- With MEM_FETCH_TIMEOUT_EN and TIMEOUT_CYC=8: host never raises rpi_ready. Expect timeout_err and ch_done pulses after 8 REQ cycles, then IDLE.

Source files
------------

// File: rtl/mem_fetch_pkg.sv
// Shared types and helpers for the host-fetch controller (mem_fetch_ctrl).
package mem_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_t;

   // Link code driven on req_type when nothing is granted.
   localparam int unsigned IDLE_TYPE = 0;

   // Channel k travels on the link as k+1 so that 0 can mean "idle".
   function automatic int unsigned chan_code(input int unsigned idx);
      return idx + 1;
   endfunction

endpackage

// File: rtl/mem_fetch_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int unsigned NUM_CH = 3,
   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   input  logic              en,
   output logic [NUM_CH-1:0] grant_c,
   output logic [IDX_W-1:0]  grant_idx_c,
   output logic              valid_c
);

   function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
      return IDX_W'(v % NUM_CH);
   endfunction

   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      valid_c     = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (en && !valid_c && req[wrap_idx(32'(ptr) + i)]) begin
            valid_c                          = 1'b1;
            grant_idx_c                      = wrap_idx(32'(ptr) + i);
            grant_c[wrap_idx(32'(ptr) + i)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_fetch_ctrl.sv
// Round-robin host-fetch controller: grants one requester at a time onto the
// host byte link and returns its burst. Optional watchdog: MEM_FETCH_TIMEOUT_EN.
module mem_fetch_ctrl
   import mem_fetch_pkg::*;
#(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned LEN_W       = 4,
   parameter int unsigned TIMEOUT_CYC = 255,
   localparam int unsigned TYPE_W     = $clog2(NUM_CH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       ch_req,
   input  logic [NUM_CH*LEN_W-1:0] ch_len,
   output logic [TYPE_W-1:0]       req_type,
   output logic                    req_valid,
   output logic [LEN_W-1:0]        req_len,
   input  logic                    rpi_ready,
   input  logic                    rpi_valid,
   input  logic [DATA_W-1:0]       rpi_in_data,
   output logic [TYPE_W-1:0]       output_sel,
   output logic [DATA_W-1:0]       out_data,
   output logic                    data_ready,
   output logic [NUM_CH-1:0]       ch_done,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("mem_fetch_ctrl: TIMEOUT_CYC must be at least 2");
   end

   state_t              state;
   logic [IDX_W-1:0]    ptr;
   logic [IDX_W-1:0]    gnt;
   logic [NUM_CH-1:0]   gnt_oh;
   logic [LEN_W-1:0]    cnt;

   logic [NUM_CH-1:0]   arb_grant_c;
   logic [IDX_W-1:0]    arb_idx_c;
   logic                arb_valid_c;
   logic [LEN_W-1:0]    sel_len_c;
   logic                wd_hit_c;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req         (ch_req),
      .ptr         (ptr),
      .en          (state == IDLE),
      .grant_c     (arb_grant_c),
      .grant_idx_c (arb_idx_c),
      .valid_c     (arb_valid_c)
   );

   assign sel_len_c = ch_len[32'(arb_idx_c)*LEN_W +: LEN_W];

`ifdef MEM_FETCH_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);
   logic [WD_W-1:0] wd;

   // Fires on the cycle that would be the TIMEOUT_CYC-th without host progress.
   assign wd_hit_c = ((state == REQ && !rpi_ready) || (state == XFER && !rpi_valid))
                     && (wd == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd <= '0;
      end else if ((state == REQ && !rpi_ready) || (state == XFER && !rpi_valid)) begin
         wd <= wd_hit_c ? '0 : wd + 1'b1;
      end else begin
         wd <= '0;
      end
   end
`else
   assign wd_hit_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         gnt         <= '0;
         gnt_oh      <= '0;
         cnt         <= '0;
         req_type    <= '0;
         req_valid   <= 1'b0;
         req_len     <= '0;
         output_sel  <= '0;
         out_data    <= '0;
         data_ready  <= 1'b0;
         ch_done     <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         data_ready  <= 1'b0;
         ch_done     <= '0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_valid_c) begin
                  gnt       <= arb_idx_c;
                  gnt_oh    <= arb_grant_c;
                  req_type  <= TYPE_W'(chan_code(32'(arb_idx_c)));
                  req_len   <= sel_len_c;
                  cnt       <= sel_len_c;
                  req_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               // A beat arriving alongside rpi_ready is deliberately dropped.
               if (rpi_ready) begin
                  req_valid <= 1'b0;
                  state     <= XFER;
               end else if (wd_hit_c) begin
                  req_valid   <= 1'b0;
                  req_type    <= TYPE_W'(IDLE_TYPE);
                  ch_done     <= gnt_oh;
                  timeout_err <= 1'b1;
                  state       <= DONE;
               end
            end
            XFER: begin
               if (rpi_valid) begin
                  out_data   <= rpi_in_data;
                  output_sel <= req_type;
                  data_ready <= 1'b1;
                  cnt        <= cnt - 1'b1;
                  if (cnt == '0) begin
                     ch_done  <= gnt_oh;
                     req_type <= TYPE_W'(IDLE_TYPE);
                     state    <= DONE;
                  end
               end else if (wd_hit_c) begin
                  req_type    <= TYPE_W'(IDLE_TYPE);
                  ch_done     <= gnt_oh;
                  timeout_err <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               ptr   <= (32'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Directed self-checking bench for mem_fetch_ctrl (NUM_CH=3, DATA_W=8, LEN_W=4).
module tb_mem_fetch_ctrl;

   localparam int unsigned NUM_CH = 3;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned LEN_W  = 4;
`ifdef MEM_FETCH_TIMEOUT_EN
   localparam int unsigned TO_CYC = 8;
`else
   localparam int unsigned TO_CYC = 255;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       ch_req;
   logic [NUM_CH*LEN_W-1:0] ch_len;
   logic [1:0]              req_type;
   logic                    req_valid;
   logic [LEN_W-1:0]        req_len;
   logic                    rpi_ready;
   logic                    rpi_valid;
   logic [DATA_W-1:0]       rpi_in_data;
   logic [1:0]              output_sel;
   logic [DATA_W-1:0]       out_data;
   logic                    data_ready;
   logic [NUM_CH-1:0]       ch_done;
   logic                    busy;
   logic                    timeout_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_fetch_ctrl #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst), .ch_req(ch_req), .ch_len(ch_len),
      .req_type(req_type), .req_valid(req_valid), .req_len(req_len),
      .rpi_ready(rpi_ready), .rpi_valid(rpi_valid), .rpi_in_data(rpi_in_data),
      .output_sel(output_sel), .out_data(out_data), .data_ready(data_ready),
      .ch_done(ch_done), .busy(busy), .timeout_err(timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge: outputs are sampled and inputs driven here.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".req_type"},   32'(req_type),   0);
      check({tag, ".req_valid"},  32'(req_valid),  0);
      check({tag, ".req_len"},    32'(req_len),    0);
      check({tag, ".output_sel"}, 32'(output_sel), 0);
      check({tag, ".out_data"},   32'(out_data),   0);
      check({tag, ".data_ready"}, 32'(data_ready), 0);
      check({tag, ".ch_done"},    32'(ch_done),    0);
      check({tag, ".busy"},       32'(busy),       0);
      check({tag, ".timeout_err"},32'(timeout_err),0);
   endtask

   initial begin
      logic [1:0] rr_exp [4];
      logic       seen;
      rr_exp = '{2'd1, 2'd2, 2'd3, 2'd1};

      rst = 1'b1; ch_req = '0; ch_len = '0;
      rpi_ready = 1'b0; rpi_valid = 1'b0; rpi_in_data = '0;
      tick(); tick();
      check_all_zero("reset");

      // Single one-beat request on channel 0.
      rst = 1'b0; ch_req = 3'b001; ch_len[0 +: 4] = 4'd0;
      tick();
      check("single.req_valid", 32'(req_valid), 1);
      check("single.req_type",  32'(req_type),  1);
      check("single.req_len",   32'(req_len),   0);
      check("single.busy",      32'(busy),      1);
      rpi_ready = 1'b1;
      tick();
      check("single.req_drop",  32'(req_valid), 0);
      rpi_ready = 1'b0; rpi_valid = 1'b1; rpi_in_data = 8'hA5;
      tick();
      check("single.data_ready", 32'(data_ready), 1);
      check("single.out_data",   32'(out_data),   32'hA5);
      check("single.output_sel", 32'(output_sel), 1);
      check("single.ch_done",    32'(ch_done),    3'b001);
      check("single.type_clear", 32'(req_type),   0);
      rpi_valid = 1'b0; ch_req = '0;
      tick();
      check("single.idle_dr",   32'(data_ready), 0);
      check("single.idle_done", 32'(ch_done),    0);
      check("single.idle_busy", 32'(busy),       0);

      // Four-beat burst on channel 2.
      ch_req = 3'b100; ch_len[8 +: 4] = 4'd3;
      tick();
      check("burst.req_type", 32'(req_type), 3);
      check("burst.req_len",  32'(req_len),  3);
      rpi_ready = 1'b1;
      tick();
      rpi_ready = 1'b0; rpi_valid = 1'b1; rpi_in_data = 8'h10;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("burst.dr%0d", i),   32'(data_ready), 1);
         check($sformatf("burst.data%0d", i), 32'(out_data),   32'h10 + 32'(i));
         check($sformatf("burst.sel%0d", i),  32'(output_sel), 3);
         check($sformatf("burst.done%0d", i), 32'(ch_done),    (i == 3) ? 32'b100 : 32'b0);
         rpi_in_data = 8'h11 + 8'(i);
      end
      rpi_valid = 1'b0; ch_req = '0;
      tick();
      check("burst.idle_busy", 32'(busy), 0);

      // Round-robin with all three requesting.
      ch_len = '0; ch_req = 3'b111;
      for (int n = 0; n < 4; n++) begin
         seen = 1'b0;
         for (int w = 0; w < 5 && !seen; w++) begin
            tick();
            seen = req_valid;
         end
         check($sformatf("rr.grant_seen%0d", n), 32'(seen), 1);
         check($sformatf("rr.type%0d", n), 32'(req_type), 32'(rr_exp[n]));
         rpi_ready = 1'b1;
         tick();
         rpi_ready = 1'b0; rpi_valid = 1'b1; rpi_in_data = 8'(n);
         tick();
         check($sformatf("rr.done%0d", n), 32'(ch_done), 32'(1) << (rr_exp[n] - 1));
         ch_req[rr_exp[n] - 1] = 1'b0; rpi_valid = 1'b0;
         tick();
         ch_req[rr_exp[n] - 1] = 1'b1;
      end
      ch_req = '0;
      tick();

      // rpi_ready and rpi_valid together in REQ: beat 0xFF must be dropped.
      ch_req = 3'b010; ch_len[4 +: 4] = 4'd1;
      tick();
      check("simul.req_type", 32'(req_type), 2);
      rpi_ready = 1'b1; rpi_valid = 1'b1; rpi_in_data = 8'hFF;
      tick();
      check("simul.req_valid", 32'(req_valid),  0);
      check("simul.no_dr",     32'(data_ready), 0);
      rpi_ready = 1'b0; rpi_in_data = 8'h21;
      tick();
      check("simul.dr1",   32'(data_ready), 1);
      check("simul.data1", 32'(out_data),   32'h21);
      check("simul.done1", 32'(ch_done),    0);
      rpi_in_data = 8'h22;
      tick();
      check("simul.dr2",   32'(data_ready), 1);
      check("simul.data2", 32'(out_data),   32'h22);
      check("simul.done2", 32'(ch_done),    3'b010);
      rpi_valid = 1'b0; ch_req = '0;
      tick();

      // Host never answers the request.
      ch_req = 3'b001; ch_len[0 +: 4] = 4'd0;
      tick();
      check("stall.req_valid", 32'(req_valid), 1);
`ifdef MEM_FETCH_TIMEOUT_EN
      for (int i = 1; i < 8; i++) tick();
      check("to.still_req", 32'(req_valid),   1);
      check("to.no_err",    32'(timeout_err), 0);
      tick();
      check("to.err",     32'(timeout_err), 1);
      check("to.done",    32'(ch_done),     3'b001);
      check("to.no_dr",   32'(data_ready),  0);
      ch_req = '0;
      tick();
      check("to.err_clr", 32'(timeout_err), 0);
      check("to.idle",    32'(busy),        0);
`else
      for (int i = 0; i < 20; i++) tick();
      check("stall.still_req", 32'(req_valid),   1);
      check("stall.no_err",    32'(timeout_err), 0);
      rpi_ready = 1'b1;
      tick();
      rpi_ready = 1'b0; rpi_valid = 1'b1; rpi_in_data = 8'h5A;
      tick();
      check("stall.data", 32'(out_data), 32'h5A);
      check("stall.done", 32'(ch_done),  3'b001);
      rpi_valid = 1'b0; ch_req = '0;
      tick();
`endif

      // Reset after two of four beats on channel 1.
      ch_req = 3'b010; ch_len[4 +: 4] = 4'd3;
      tick();
      check("abort.req_type", 32'(req_type), 2);
      rpi_ready = 1'b1;
      tick();
      rpi_ready = 1'b0; rpi_valid = 1'b1; rpi_in_data = 8'h31;
      tick();
      rpi_in_data = 8'h32;
      tick();
      check("abort.beat2", 32'(out_data), 32'h32);
      rst = 1'b1; rpi_valid = 1'b0; ch_req = '0;
      tick();
      check_all_zero("abort");
      rst = 1'b0; ch_req = 3'b111;
      tick();
      check("abort.regrant_type", 32'(req_type), 1);
      check("abort.no_done",      32'(ch_done),  0);
      ch_req = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
